// File: rtl/ring_icon_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module : ring_icon_blink_pkg
// Brief  : Shared state encodings and widths for the alarm ringing icon.
// Rev    : 1.0  initial release
// ============================================================================
package ring_icon_blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RING_ON  = 2'd1,
    ST_RING_OFF = 2'd2,
    ST_ACKED    = 2'd3
  } state_t;

  localparam int c_ROM_AW = 7;
  localparam int c_ROM_DW = 8;
  localparam int c_RGB_W  = 12;

endpackage
`default_nettype wire

// File: rtl/ring_glyph_rom.sv
`default_nettype none
// ============================================================================
// Module : ring_glyph_rom
// Brief  : 128x8 registered-read glyph ROM; bell tiles, clapper frame by swing.
// Rev    : 1.0  initial release
// ============================================================================
module ring_glyph_rom
  import ring_icon_blink_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [c_ROM_AW-1:0] addr,
  output logic [c_ROM_DW-1:0] data
);

  // One 16-pixel bell row spans tiles 0 and 1; only the clapper rows move.
  function automatic logic [15:0] f_bell_row(input logic swing, input logic [3:0] row);
    case (row)
      4'd0:                f_bell_row = 16'h8181;
      4'd1:                f_bell_row = 16'h43C2;
      4'd2:                f_bell_row = 16'h07E0;
      4'd3:                f_bell_row = 16'h0FF0;
      4'd4, 4'd5, 4'd6:    f_bell_row = 16'h1FF8;
      4'd7, 4'd8:          f_bell_row = 16'h3FFC;
      4'd9:                f_bell_row = 16'h7FFE;
      4'd10, 4'd11:        f_bell_row = 16'hFFFF;
      4'd12:               f_bell_row = 16'h0180;
      4'd13:               f_bell_row = swing ? 16'h00C0 : 16'h0300;
      4'd14:               f_bell_row = swing ? 16'h0060 : 16'h0600;
      default:             f_bell_row = 16'h0000;
    endcase
  endfunction

  logic [15:0]         w_row;
  logic [c_ROM_DW-1:0] w_byte;

  always_comb begin
    w_row = f_bell_row(addr[6], addr[3:0]);
    case (addr[5:4])
      2'd0:    w_byte = w_row[15:8];
      2'd1:    w_byte = w_row[7:0];
      default: w_byte = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data <= '0;
    else        data <= w_byte;
  end

endmodule
`default_nettype wire

// File: rtl/ring_icon_blink.sv
`default_nettype none
// ============================================================================
// Module : ring_icon_blink
// Brief  : Blinking, swinging alarm-bell icon layer with fixed 3-clk pixel latency.
// Rev    : 1.0  initial release
// ============================================================================
module ring_icon_blink
  import ring_icon_blink_pkg::*;
#(
  parameter int                 X0           = 576,
  parameter int                 Y0           = 320,
  parameter int                 N_TILES      = 2,
  parameter int                 SX           = 2,
  parameter int                 SY           = 2,
  parameter int                 BLINK_FRAMES = 30,
  parameter logic [c_RGB_W-1:0] FG_COLOR     = 12'hFFF
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               ack,
  input  logic               frame_tick,
  input  logic               video_on,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic [c_RGB_W-1:0] rgb_out,
  output logic               icon_on,
  output logic               ringing
);

  localparam int c_W  = N_TILES * (8 << SX);
  localparam int c_H  = 16 << SY;
  localparam int c_CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_CW-1:0] c_TERM = c_CW'(BLINK_FRAMES - 1);
  localparam logic [10:0] c_X_LO = 11'(X0);
  localparam logic [10:0] c_X_HI = 11'(X0 + c_W);
  localparam logic [10:0] c_Y_LO = 11'(Y0);
  localparam logic [10:0] c_Y_HI = 11'(Y0 + c_H);

  state_t             r_state;
  logic [c_CW-1:0]    r_cnt;
  logic               r_swing;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_swing <= 1'b0;
      ringing <= 1'b0;
    end else if (!enable) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_swing <= 1'b0;
      ringing <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_RING_ON;
          r_cnt   <= '0;
          ringing <= 1'b1;
        end
        ST_RING_ON, ST_RING_OFF: begin
          if (ack) begin
            r_state <= ST_ACKED;
            ringing <= 1'b0;
          end else if (frame_tick) begin
            if (r_cnt == c_TERM) begin
              r_cnt <= '0;
              if (r_state == ST_RING_ON) begin
                r_state <= ST_RING_OFF;
              end else begin
                r_state <= ST_RING_ON;
                r_swing <= ~r_swing;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_ACKED;
      endcase
    end
  end

  // Address generation; 11-bit compares keep X0+width from wrapping.
  logic [10:0]         w_px, w_py;
  logic [9:0]          w_dx, w_dy;
  logic                w_hit;
  logic [c_ROM_AW-1:0] w_addr;
  logic                w_unused;

  assign w_px     = {1'b0, pix_x};
  assign w_py     = {1'b0, pix_y};
  assign w_dx     = pix_x - 10'(X0);
  assign w_dy     = pix_y - 10'(Y0);
  assign w_hit    = (w_px >= c_X_LO) && (w_px < c_X_HI) && (w_py >= c_Y_LO) && (w_py < c_Y_HI);
  assign w_addr   = {r_swing, w_dx[SX+4:SX+3], w_dy[SY+3:SY]};
  assign w_unused = ^{w_dx, w_dy};

  logic                r1_hit, r1_von, r2_hit, r2_von;
  logic [2:0]          r1_col, r2_col;
  logic [c_ROM_AW-1:0] r1_addr;
  logic [c_ROM_DW-1:0] w_rom_data;
  logic                w_bit, w_icon_next;

  ring_glyph_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (r1_addr),
    .data  (w_rom_data)
  );

  assign w_bit       = w_rom_data[3'd7 - r2_col];
  assign w_icon_next = r2_hit & r2_von & (r_state == ST_RING_ON);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_hit  <= 1'b0;
      r1_von  <= 1'b0;
      r1_col  <= '0;
      r1_addr <= '0;
      r2_hit  <= 1'b0;
      r2_von  <= 1'b0;
      r2_col  <= '0;
      icon_on <= 1'b0;
      rgb_out <= '0;
    end else begin
      r1_hit  <= w_hit;
      r1_von  <= video_on;
      r1_col  <= w_dx[SX+2:SX];
      r1_addr <= w_addr;
      r2_hit  <= r1_hit;
      r2_von  <= r1_von;
      r2_col  <= r1_col;
      icon_on <= w_icon_next;
      rgb_out <= (w_icon_next & w_bit) ? FG_COLOR : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_icon_blink.sv
`default_nettype none
// ============================================================================
// Module : tb_ring_icon_blink
// Brief  : Self-checking bench for ring_icon_blink (vector table + scoreboard).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ring_icon_blink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        ack = 1'b0;
  logic        frame_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [11:0] rgb_out;
  logic        icon_on;
  logic        ringing;

  ring_icon_blink dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ack        (ack),
    .frame_tick (frame_tick),
    .video_on   (video_on),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .rgb_out    (rgb_out),
    .icon_on    (icon_on),
    .ringing    (ringing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic        icon;
    logic [11:0] rgb;
  } vec_t;

  typedef struct {
    logic        icon;
    logic [11:0] rgb;
    string       nm;
  } exp_t;

  exp_t q[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference bell art: 16 pixels per row across tile 0 (high byte) and tile 1.
  function automatic logic [15:0] ref_row(input logic sw, input int r);
    logic [15:0] v;
    case (r)
      0: v = 16'b1000_0001_1000_0001;
      1: v = 16'b0100_0011_1100_0010;
      2: v = 16'b0000_0111_1110_0000;
      3: v = 16'b0000_1111_1111_0000;
      4, 5, 6: v = 16'b0001_1111_1111_1000;
      7, 8: v = 16'b0011_1111_1111_1100;
      9: v = 16'b0111_1111_1111_1110;
      10, 11: v = 16'hFFFF;
      12: v = 16'b0000_0001_1000_0000;
      13: v = sw ? 16'b0000_0000_1100_0000 : 16'b0000_0011_0000_0000;
      14: v = sw ? 16'b0000_0000_0110_0000 : 16'b0000_0110_0000_0000;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  function automatic logic [12:0] model(input int x, input int y, input logic von,
                                        input logic vis, input logic sw);
    int dx, dy, tile, col, row;
    logic [15:0] bits;
    logic on, b;
    if (x < 576 || x > 639 || y < 320 || y > 383) return 13'd0;
    dx = x - 576; dy = y - 320;
    tile = dx / 32; col = (dx % 32) / 4; row = dy / 4;
    bits = ref_row(sw, row);
    b  = bits[15 - (tile * 8 + col)];
    on = von & vis;
    return {on, (on & b) ? 12'hFFF : 12'h000};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = q.pop_front();
    check({e.nm, "_rgb"}, 32'(rgb_out), 32'(e.rgb));
    check({e.nm, "_icon"}, 32'(icon_on), 32'(e.icon));
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic von,
                      input logic ie, input logic [11:0] re, input string nm);
    exp_t e;
    @(negedge clk);
    if (q.size() >= 3) pop_check();
    pix_x = x; pix_y = y; video_on = von;
    e.icon = ie; e.rgb = re; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic mstep(input int x, input int y, input logic vis, input logic sw, input string nm);
    logic [12:0] m;
    m = model(x, y, 1'b1, vis, sw);
    step(10'(x), 10'(y), 1'b1, m[12], m[11:0], nm);
  endtask

  task automatic drain();
    repeat (3) step(10'd0, 10'd0, 1'b0, 1'b0, 12'h000, "pad");
    repeat (3) begin
      @(negedge clk);
      pop_check();
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  initial begin
    vecs[0]  = '{10'd576, 10'd320, 1'b1, 1'b1, 12'hFFF};
    vecs[1]  = '{10'd575, 10'd320, 1'b1, 1'b0, 12'h000};
    vecs[2]  = '{10'd640, 10'd320, 1'b1, 1'b0, 12'h000};
    vecs[3]  = '{10'd576, 10'd384, 1'b1, 1'b0, 12'h000};
    vecs[4]  = '{10'd639, 10'd383, 1'b1, 1'b1, 12'h000};
    vecs[5]  = '{10'd604, 10'd320, 1'b1, 1'b1, 12'hFFF};
    vecs[6]  = '{10'd600, 10'd372, 1'b1, 1'b1, 12'hFFF};
    vecs[7]  = '{10'd608, 10'd372, 1'b1, 1'b1, 12'h000};
    vecs[8]  = '{10'd592, 10'd360, 1'b1, 1'b1, 12'hFFF};
    vecs[9]  = '{10'd576, 10'd360, 1'b0, 1'b0, 12'h000};
    vecs[10] = '{10'd584, 10'd324, 1'b1, 1'b1, 12'h000};
    vecs[11] = '{10'd580, 10'd324, 1'b1, 1'b1, 12'hFFF};

    // Reset held with an in-region visible pixel
    pix_x = 10'd580; pix_y = 10'd330; video_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rgb", 32'(rgb_out), 32'h0);
    check("rst_icon", 32'(icon_on), 32'h0);
    check("rst_ringing", 32'(ringing), 32'h0);
    reset = 1'b1;
    repeat (5) step(10'd580, 10'd330, 1'b1, 1'b0, 12'h000, "idle");
    drain();
    check("idle_ringing", 32'(ringing), 32'h0);

    // Ringing, swing 0: table-driven pixels
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    check("en_ringing", 32'(ringing), 32'h1);
    for (int i = 0; i < 12; i++)
      step(vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].icon, vecs[i].rgb, $sformatf("vec%0d", i));
    for (int i = 0; i < 24; i++)
      mstep(560 + int'($urandom_range(0, 95)), 310 + int'($urandom_range(0, 85)), 1'b1, 1'b0, "rand0");
    drain();

    // Blink: 29 ticks still lit, 30th goes dark, 30 more relight with swing 1
    ticks(29);
    step(10'd576, 10'd320, 1'b1, 1'b1, 12'hFFF, "t29_vis");
    drain();
    ticks(1);
    step(10'd576, 10'd320, 1'b1, 1'b0, 12'h000, "off_dark");
    drain();
    check("off_ringing", 32'(ringing), 32'h1);
    ticks(29);
    step(10'd576, 10'd320, 1'b1, 1'b0, 12'h000, "off29_dark");
    drain();
    ticks(1);
    step(10'd608, 10'd320, 1'b1, 1'b1, 12'hFFF, "sw1_addr50");
    step(10'd608, 10'd372, 1'b1, 1'b1, 12'hFFF, "sw1_clap_r");
    step(10'd600, 10'd372, 1'b1, 1'b1, 12'h000, "sw1_clap_l");
    for (int i = 0; i < 16; i++)
      mstep(570 + int'($urandom_range(0, 75)), 316 + int'($urandom_range(0, 72)), 1'b1, 1'b1, "rand1");
    drain();

    // Acknowledge silences; enable toggle restarts with swing 0, cnt 0
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    check("ack_ringing", 32'(ringing), 32'h0);
    step(10'd576, 10'd320, 1'b1, 1'b0, 12'h000, "ack_dark");
    drain();
    @(negedge clk); enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    check("reen_ringing", 32'(ringing), 32'h1);
    step(10'd600, 10'd372, 1'b1, 1'b1, 12'hFFF, "reen_sw0");
    drain();
    ticks(29);
    step(10'd576, 10'd320, 1'b1, 1'b1, 12'hFFF, "reen_t29");
    drain();
    ticks(1);
    step(10'd576, 10'd320, 1'b1, 1'b0, 12'h000, "reen_t30");
    drain();

    // Tick and ack together at terminal count: ack wins
    ticks(59);
    @(negedge clk); ack = 1'b1; frame_tick = 1'b1;
    @(negedge clk); ack = 1'b0; frame_tick = 1'b0;
    check("tickack_ringing", 32'(ringing), 32'h0);
    ticks(31);
    check("acked_hold", 32'(ringing), 32'h0);
    step(10'd576, 10'd320, 1'b1, 1'b0, 12'h000, "acked_dark");
    drain();
    @(negedge clk); enable = 1'b0; ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    check("dis_ringing", 32'(ringing), 32'h0);
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    check("idle_restart", 32'(ringing), 32'h1);

    // video_on low inside region, then async reset mid-line
    step(10'd576, 10'd320, 1'b0, 1'b0, 12'h000, "von0");
    repeat (5) step(10'd576, 10'd320, 1'b1, 1'b1, 12'hFFF, "pre_rst");
    check("pre_rst_lit", 32'(rgb_out), 32'hFFF);
    #2 reset = 1'b0;
    #1;
    check("async_rgb", 32'(rgb_out), 32'h0);
    check("async_icon", 32'(icon_on), 32'h0);
    check("async_ringing", 32'(ringing), 32'h0);
    q.delete();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("post_rst_ringing", 32'(ringing), 32'h1);
    repeat (4) step(10'd576, 10'd320, 1'b1, 1'b1, 12'hFFF, "refill");
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
